// File: rtl/pipe_addsub.sv
// pipe_addsub: chunked, pipelined add/subtract with carry/borrow, overflow and zero flags
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_a, in_b, in_sub: 0 = a+b, 1 = a-b)
//   out_valid/out_ready  : result handshake (out_sum, out_cf, out_of, out_zf)
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cf,
    output logic             out_of,
    output logic             out_zf
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_width_check
        $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
    end

    logic              adv;
    logic              loaded;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] sub_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [C:0]        part [STAGES];
    logic [WIDTH-1:0]  sum_fin;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // b_q already holds B' (inverted for subtraction); stage k adds its chunk plus the carry of k-1
    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        assign part[k] = {1'b0, a_q[k][k*C +: C]} + {1'b0, b_q[k][k*C +: C]} + {{C{1'b0}}, c_q[k]};
    end

    always_comb begin
        sum_fin = s_q[L];
        sum_fin[L*C +: C] = part[L][C-1:0];
    end

    // loaded keeps the zero flag low until a real result has reached the output
    assign out_zf = loaded && (out_sum == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            c_q       <= '0;
            sub_q     <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cf    <= 1'b0;
            out_of    <= 1'b0;
            loaded    <= 1'b0;
        end else if (adv) begin
            v_q[0]   <= in_valid;
            a_q[0]   <= in_a;
            b_q[0]   <= in_sub ? ~in_b : in_b;
            c_q[0]   <= in_sub;
            sub_q[0] <= in_sub;
            s_q[0]   <= '0;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k]   <= v_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                sub_q[k] <= sub_q[k-1];
                c_q[k]   <= part[k-1][C];
                s_q[k]   <= s_q[k-1];
                s_q[k][(k-1)*C +: C] <= part[k-1][C-1:0];
            end
            out_valid <= v_q[L];
            if (v_q[L]) begin
                out_sum <= sum_fin;
                out_cf  <= part[L][C] ^ sub_q[L];
                out_of  <= (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (sum_fin[WIDTH-1] != a_q[L][WIDTH-1]);
                loaded  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: table-driven and scoreboard checks of pipe_addsub (WIDTH=32, STAGES=4)
module tb_pipe_addsub;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 0, rst_n = 0, in_valid = 0, in_sub = 0, out_ready = 1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_cf, out_of, out_zf;
    logic [W-1:0] out_sum;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cf(out_cf),
        .out_of(out_of), .out_zf(out_zf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cf;
        logic         of;
        logic         zf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        res_t         exp;
    } vec_t;

    res_t   q[$];
    vec_t   tbl[10];
    int     checks = 0, failures = 0;
    int     run = 0, max_run = 0;
    logic   held = 0;
    res_t   prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t r;
        logic [W:0] w;
        w    = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        r.sum = w[W-1:0];
        r.cf  = w[W];
        r.of  = sub ? (a[W-1] != b[W-1] && r.sum[W-1] != a[W-1])
                    : (a[W-1] == b[W-1] && r.sum[W-1] != a[W-1]);
        r.zf  = (r.sum == '0);
        return r;
    endfunction

    // scoreboard side: pop on each output transfer, watch stalls for frozen outputs
    always @(negedge clk) begin
        res_t cur, e;
        cur = '{out_sum, out_cf, out_of, out_zf};
        if (rst_n) begin
            if (out_valid && out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h expected=none", cur);
                end else begin
                    e = q.pop_front();
                    check("result", 64'(cur), 64'(e));
                end
            end else begin
                run = 0;
            end
            if (out_valid && !out_ready) begin
                check("in_ready_stall", 64'(in_ready), 64'(0));
                if (held) check("stall_hold", 64'(cur), 64'(prev));
                held = 1;
                prev = cur;
            end else begin
                held = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input res_t e);
        logic acc;
        acc      = 0;
        in_valid = 1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) q.push_back(e);
        else check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        in_valid = 0;
        for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic latency();
        for (int i = 1; i < S; i++) begin
            @(posedge clk);
            #1;
            check("latency_early", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        check("latency_due", 64'(out_valid), 64'(1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           stale;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        tbl[6] = '{32'h0000_0000, 32'h8000_0000, 1'b1, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
        tbl[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, '{32'h2345_6789, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
        tbl[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}};

        #12;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_flags", {out_sum, out_cf, out_of, out_zf}, 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1;

        send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].exp);
        in_valid = 0;
        latency();
        drain();

        for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].exp);
        drain();

        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom);
            send(a, b, s, model(a, b, s));
        end
        drain();
        check("stream_run8", 64'(max_run >= 8), 64'(1));

        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    a = pick();
                    b = pick();
                    s = 1'($urandom);
                    send(a, b, s, model(a, b, s));
                    if (i == 4) begin
                        in_valid = 0;
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                check("stall_precond", 64'(out_valid), 64'(1));
                out_ready = 0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();

        for (int i = 0; i < 4; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom);
            send(a, b, s, model(a, b, s));
        end
        in_valid = 0;
        @(posedge clk);
        #2;
        check("reset_precond", 64'(out_valid), 64'(1));
        rst_n = 0;
        #1;
        check("async_clear_valid", 64'(out_valid), 64'(0));
        check("async_clear_data", {out_sum, out_cf, out_of, out_zf}, 64'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            stale += int'(out_valid);
        end
        check("no_stale_after_reset", 64'(stale), 64'(0));

        send(32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        in_valid = 0;
        latency();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, and a non-multiple SHALL fail elaboration.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port in_a  input  WIDTH  operand A.
REQ-008 Port in_b  input  WIDTH  operand B.
REQ-009 Port in_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port out_sum  output  WIDTH  result.
REQ-013 Port out_cf  output  1  add: carry out; sub: borrow (A<B unsigned).
REQ-014 Port out_of  output  1  two's-complement signed overflow.
REQ-015 Port out_zf  output  1  out_sum is all zeros.

Function
REQ-016 Each operation SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k SHALL add chunk k (LSB first) plus the registered carry from stage k-1.
REQ-017 Subtraction SHALL compute A + ~B + 1, with carry-in 1 at chunk 0; addition SHALL use carry-in 0.
REQ-018 Unprocessed upper chunks of A and B, and in_sub, SHALL travel with each operand set through the stage registers.
REQ-019 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-020 Global advance: adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-021 When adv=0, every stage register, valid bit, and output SHALL hold its value.
REQ-022 When adv=1, each stage valid bit SHALL shift one stage; stage 0 valid SHALL load in_valid.
REQ-023 Latency: an operand set accepted at edge n, with adv=1 throughout, SHALL show out_valid=1 with its result after edge n+STAGES.
REQ-024 Throughput SHALL be one operation per cycle while out_ready=1; with no stall, results SHALL leave in acceptance order, with none lost or duplicated.
REQ-025 Bubbles (in_valid=0 cycles) SHALL propagate as invalid slots and are not collapsed.
REQ-026 out_cf SHALL be the final carry for add and its inverse for sub.
REQ-027 out_of SHALL be 1 when the MSBs of A and B' (B for add, ~B for sub) are equal and the result MSB differs from them.
REQ-028 out_zf SHALL be derived from the registered out_sum.
REQ-029 out_sum and all flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 Results SHALL be exact modulo 2^WIDTH for all operand values, including 0, all-ones, and the most-negative value.

Reset
REQ-031 rst_n=0 SHALL immediately clear all stage valid bits and out_valid, and set out_sum=0, out_cf=0, out_of=0 and out_zf=0, without waiting for clk.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-033 After rst_n rises, the first accepted operand set SHALL follow the latency in REQ-023.

Verification (WIDTH=32, STAGES=4)
REQ-034 add 0xFFFFFFFF+0x00000001, out_ready=1 -> 4 cycles later: out_sum=0x00000000, cf=1, zf=1, of=0.
REQ-035 add 0x7FFFFFFF+0x00000001 -> out_sum=0x80000000, of=1, cf=0, zf=0; sub 0x80000000-0x00000001 -> out_sum=0x7FFFFFFF, of=1, cf=0.
REQ-036 sub 0x00000005-0x00000007 -> out_sum=0xFFFFFFFE, cf=1, of=0; sub 0x12345678-0x12345678 -> out_sum=0, zf=1, cf=0.
REQ-037 Stream 8 random add/sub operations back-to-back with out_ready=1 -> 8 consecutive out_valid cycles matching the reference model in order.
REQ-038 Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and outputs frozen for those cycles, then the stream resumes with no loss or duplication.
REQ-039 Assert rst_n=0 between clock edges with 3 operations in flight -> outputs clear immediately; after release, no stale out_valid appears.
